// File: rtl/vector_lane_sequencer_pkg.sv
// Shared definitions for the vector lane sequencer and the vector ALU beside it:
// opcode values, FSM encoding and the default lane geometry.
package vector_lane_sequencer_pkg;

    localparam int LANES_DEFAULT  = 4;
    localparam int LANE_W_DEFAULT = 8;

    localparam logic [2:0] VOP_ADD = 3'b000;
    localparam logic [2:0] VOP_MUL = 3'b001;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } seq_state_t;

    function automatic logic is_legal_op(input logic [2:0] op);
        return (op == VOP_ADD) || (op == VOP_MUL);
    endfunction

endpackage

// File: rtl/vector_lane_sequencer.sv
// Feeds one lane per cycle of two latched vector operands to the external ALU and
// reassembles the per-lane results into a packed vector, with start/busy/done handshake.
module vector_lane_sequencer
    import vector_lane_sequencer_pkg::*;
#(
    parameter int LANES  = LANES_DEFAULT,
    parameter int LANE_W = LANE_W_DEFAULT
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      start,
    input  logic [2:0]                op,
    input  logic [LANES*LANE_W-1:0]   vec_a,
    input  logic [LANES*LANE_W-1:0]   vec_b,
    output logic                      busy,
    output logic                      done,
    output logic                      err,
    output logic [LANES*LANE_W-1:0]   result,
    output logic [LANE_W-1:0]         valu_in1,
    output logic [LANE_W-1:0]         valu_in2,
    output logic [2:0]                valu_op,
    input  logic [LANE_W-1:0]         valu_out
);

    localparam int CNT_W = (LANES > 1) ? $clog2(LANES) : 1;

    seq_state_t                 state_reg, state_next;
    logic [CNT_W-1:0]           cnt_reg, cnt_next;
    logic [LANES*LANE_W-1:0]    a_reg, a_next;
    logic [LANES*LANE_W-1:0]    b_reg, b_next;
    logic [2:0]                 op_reg, op_next;
    logic                       err_reg, err_next;

    logic [LANE_W-1:0]          a_lane [LANES];
    logic [LANE_W-1:0]          b_lane [LANES];
    logic [LANE_W-1:0]          result_lane_reg [LANES];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
            op_reg    <= '0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            a_reg     <= a_next;
            b_reg     <= b_next;
            op_reg    <= op_next;
            err_reg   <= err_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        a_next     = a_reg;
        b_next     = b_reg;
        op_next    = op_reg;
        err_next   = err_reg;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    a_next   = vec_a;
                    b_next   = vec_b;
                    op_next  = op;
                    cnt_next = '0;
                    // An illegal op skips the lane walk and reports through err.
                    if (is_legal_op(op)) begin
                        state_next = RUN;
                        err_next   = 1'b0;
                    end else begin
                        state_next = DONE;
                        err_next   = 1'b1;
                    end
                end
            end
            RUN: begin
                if (cnt_reg == CNT_W'(LANES - 1)) begin
                    cnt_next   = '0;
                    state_next = DONE;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            DONE: begin
                state_next = IDLE;
                err_next   = 1'b0;
            end
            default: begin
                state_next = IDLE;
                err_next   = 1'b0;
            end
        endcase
    end

    // Each lane owns its own result register, written only while it is the active lane.
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        assign a_lane[gi] = a_reg[gi*LANE_W +: LANE_W];
        assign b_lane[gi] = b_reg[gi*LANE_W +: LANE_W];
        assign result[gi*LANE_W +: LANE_W] = result_lane_reg[gi];

        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                result_lane_reg[gi] <= '0;
            end else if ((state_reg == RUN) && (cnt_reg == CNT_W'(gi))) begin
                result_lane_reg[gi] <= valu_out;
            end
        end
    end

    // The ALU inputs are zeroed outside RUN so it never sees stale operands.
    always_comb begin
        valu_in1 = '0;
        valu_in2 = '0;
        valu_op  = '0;
        if (state_reg == RUN) begin
            valu_in1 = a_lane[cnt_reg];
            valu_in2 = b_lane[cnt_reg];
            valu_op  = op_reg;
        end
    end

    assign busy = (state_reg == RUN) || (state_reg == DONE);
    assign done = (state_reg == DONE);
    assign err  = err_reg;

endmodule

// File: tb/tb_vector_lane_sequencer.sv
// Self-checking bench: behavioural ALU beside the sequencer, directed cases plus
// randomized operations compared against a lane-by-lane arithmetic reference.
module tb_vector_lane_sequencer;

    localparam int LANES  = 4;
    localparam int LANE_W = 8;
    localparam int VW     = LANES * LANE_W;

    logic              clk;
    logic              reset;
    logic              start;
    logic [2:0]        op;
    logic [VW-1:0]     vec_a;
    logic [VW-1:0]     vec_b;
    logic              busy;
    logic              done;
    logic              err;
    logic [VW-1:0]     result;
    logic [LANE_W-1:0] valu_in1;
    logic [LANE_W-1:0] valu_in2;
    logic [2:0]        valu_op;
    logic [LANE_W-1:0] valu_out;

    int checks   = 0;
    int failures = 0;
    logic [VW-1:0] model_result;

    vector_lane_sequencer #(.LANES(LANES), .LANE_W(LANE_W)) dut (
        .clock    (clk),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .vec_a    (vec_a),
        .vec_b    (vec_b),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .result   (result),
        .valu_in1 (valu_in1),
        .valu_in2 (valu_in2),
        .valu_op  (valu_op),
        .valu_out (valu_out)
    );

    // Behavioural stand-in for the combinational vector ALU.
    assign valu_out = (valu_op == 3'b000) ? LANE_W'(valu_in1 + valu_in2) :
                      (valu_op == 3'b001) ? LANE_W'(valu_in1 * valu_in2) : '0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [VW-1:0] ref_vec(input logic [VW-1:0] a, input logic [VW-1:0] b,
                                              input logic [2:0] o);
        logic [VW-1:0] r;
        int unsigned la, lb;
        r = '0;
        for (int i = 0; i < LANES; i++) begin
            la = a[i*LANE_W +: LANE_W];
            lb = b[i*LANE_W +: LANE_W];
            if (o == 3'b000) r[i*LANE_W +: LANE_W] = LANE_W'((la + lb) % 256);
            else             r[i*LANE_W +: LANE_W] = LANE_W'((la * lb) % 256);
        end
        return r;
    endfunction

    // One complete operation from the start edge through the return to IDLE.
    task automatic do_op(input logic [VW-1:0] a, input logic [VW-1:0] b, input logic [2:0] o,
                         input string tag);
        logic          exp_err;
        logic [VW-1:0] exp_res;
        int            lat;
        exp_err = !((o == 3'b000) || (o == 3'b001));
        exp_res = exp_err ? model_result : ref_vec(a, b, o);
        @(negedge clk);
        start = 1'b1; vec_a = a; vec_b = b; op = o;
        @(posedge clk); #1;
        start = 1'b0; vec_a = $urandom; vec_b = $urandom; op = 3'($urandom);
        check_eq({tag, "_busy"}, VW'(busy), VW'(1));
        if (!exp_err) begin
            check_eq({tag, "_in1_lane0"}, VW'(valu_in1), VW'(a[LANE_W-1:0]));
            check_eq({tag, "_in2_lane0"}, VW'(valu_in2), VW'(b[LANE_W-1:0]));
        end
        lat = 1;
        while (!done && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check_eq({tag, "_latency"}, VW'(lat), exp_err ? VW'(1) : VW'(LANES + 1));
        check_eq({tag, "_err"}, VW'(err), VW'(exp_err));
        check_eq({tag, "_result"}, result, exp_res);
        @(posedge clk); #1;
        check_eq({tag, "_idle_done"}, VW'(done), VW'(0));
        check_eq({tag, "_idle_busy"}, VW'(busy), VW'(0));
        check_eq({tag, "_idle_err"}, VW'(err), VW'(0));
        check_eq({tag, "_idle_alu"}, VW'({valu_in1, valu_in2, valu_op}), VW'(0));
        $display("op %s a=0x%08h b=0x%08h op=%0d result=0x%08h err=%0b lat=%0d",
                 tag, a, b, o, result, err, lat);
        model_result = exp_res;
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (!done && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check_eq({tag, "_done_seen"}, VW'(done), VW'(1));
    endtask

    initial begin
        logic [VW-1:0] a1, b1, a2, b2;
        logic [2:0]    ro;
        int            seen;
        reset = 1'b1; start = 1'b0; op = '0; vec_a = '0; vec_b = '0;
        model_result = '0;
        #12;
        check_eq("rst_busy", VW'(busy), VW'(0));
        check_eq("rst_done", VW'(done), VW'(0));
        check_eq("rst_err", VW'(err), VW'(0));
        check_eq("rst_result", result, '0);
        check_eq("rst_alu", VW'({valu_in1, valu_in2, valu_op}), VW'(0));
        @(negedge clk); reset = 1'b0;

        do_op(32'h04030201, 32'h10203040, 3'b000, "add");
        check_eq("add_const", result, 32'h14233241);
        do_op(32'h04030201, 32'h10203040, 3'b011, "illegal");
        check_eq("illegal_keep", result, 32'h14233241);
        do_op(32'h02100F03, 32'h03100211, 3'b001, "mul");
        check_eq("mul_const", result, 32'h06001E33);
        do_op(32'hFFFFFFFF, 32'h01010101, 3'b000, "add_wrap");
        check_eq("wrap_const", result, 32'h00000000);

        // Reset in the middle of a run: no done pulse, result cleared.
        @(negedge clk);
        start = 1'b1; vec_a = 32'h11223344; vec_b = 32'h01010101; op = 3'b000;
        @(posedge clk); #1; start = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b1; #1;
        check_eq("midrst_busy", VW'(busy), VW'(0));
        check_eq("midrst_result", result, '0);
        check_eq("midrst_alu", VW'({valu_in1, valu_in2, valu_op}), VW'(0));
        @(negedge clk); reset = 1'b0;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (done) seen++;
        end
        check_eq("midrst_no_done", VW'(seen), VW'(0));
        $display("op midrst result=0x%08h done_pulses=%0d", result, seen);
        model_result = '0;
        do_op(32'h11223344, 32'h01010101, 3'b000, "after_rst");

        // start held high across two back-to-back operations.
        a1 = $urandom; b1 = $urandom; a2 = $urandom; b2 = $urandom;
        @(negedge clk);
        start = 1'b1; vec_a = a1; vec_b = b1; op = 3'b000;
        @(posedge clk); #1;
        vec_a = a2; vec_b = b2;
        wait_done("held1");
        check_eq("held1_result", result, ref_vec(a1, b1, 3'b000));
        @(posedge clk); #1;
        check_eq("held_gap_busy", VW'(busy), VW'(0));
        @(posedge clk); #1;
        check_eq("held_restart_busy", VW'(busy), VW'(1));
        start = 1'b0;
        wait_done("held2");
        check_eq("held2_result", result, ref_vec(a2, b2, 3'b000));
        $display("op held a1=0x%08h a2=0x%08h result=0x%08h", a1, a2, result);
        model_result = result;
        @(posedge clk); #1;

        for (int t = 0; t < 12; t++) begin
            case ($urandom_range(0, 4))
                0, 1:    ro = 3'b000;
                2, 3:    ro = 3'b001;
                default: ro = 3'($urandom_range(2, 7));
            endcase
            do_op($urandom, $urandom, ro, $sformatf("rnd%0d", t));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vector_lane_sequencer.md
Name: vector_lane_sequencer

Overview:
- Multicycle operand sequencer wrapped around the combinational 8-bit vector ALU.
- Accepts two packed vector operands (LANES x LANE_W bits) plus an opcode, and presents one lane per cycle to the ALU inputs.
- Captures each lane's ALU result and reassembles a packed result vector, with a start/busy/done handshake toward the processor control FSM.

Parameters:
- LANES, 4, number of lanes per vector; must be >= 2.
- LANE_W, 8, bits per lane; must match the ALU data width.

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request a vector operation; sampled only in IDLE.
- op  input  3  vector opcode: 000 = ADD, 001 = MUL; all other codes are illegal.
- vec_a  input  LANES*LANE_W  operand A; lane i = bits [i*LANE_W +: LANE_W].
- vec_b  input  LANES*LANE_W  operand B; same packing as vec_a.
- busy  output  1  high in RUN and DONE.
- done  output  1  one-cycle completion pulse.
- err  output  1  high together with done when the latched op was illegal.
- result  output  LANES*LANE_W  packed result; same packing as the operands.
- valu_in1  output  LANE_W  ALU operand 1 (current lane of A).
- valu_in2  output  LANE_W  ALU operand 2 (current lane of B).
- valu_op  output  3  ALU opcode.
- valu_out  input  LANE_W  ALU result for the current lane.

Behaviour:
- Reset (asynchronous, any state): state = IDLE; busy, done, err, result, valu_in1, valu_in2, valu_op = 0; lane counter = 0; operand and op latches = 0.
- FSM states are IDLE, RUN and DONE.
- IDLE, on start = 1 at a rising edge:
  - Latch vec_a, vec_b and op; lane counter = 0.
  - Legal op: go to RUN.
  - Illegal op: go to DONE with err = 1; result is unchanged.
- IDLE, on start = 0: remain in IDLE.
- RUN, combinational ALU drive: valu_in1 and valu_in2 are the latched lane[cnt]; valu_op is the latched op.
- RUN, each rising edge: result lane[cnt] <= valu_out, then cnt += 1.
  - After capturing lane LANES-1, go to DONE; the counter wraps to 0.
- DONE: done = 1 for exactly one cycle, then return to IDLE unconditionally. err clears on leaving DONE.
- Latency: start sampled at edge E0; lanes captured at edges E1..E_LANES; done high in the cycle after E_LANES. Total is LANES+1 cycles from start to done (5 cycles at the default).
- ALU drive outside RUN: valu_in1, valu_in2 and valu_op are forced to 0. This prevents the combinational ALU from holding stale values.
- start while busy (RUN or DONE): ignored; no queueing. Back-to-back operation needs start in the IDLE cycle after done.
- Operand changes after E0: no effect, because the operands are latched.
- result holds its last value until overwritten lane by lane in the next RUN. During RUN it is partially updated; it is valid only when done = 1 and err = 0.
- Width rules: lanes are independent with no carry between them. Results are the low LANE_W bits from the ALU, so ADD wraps modulo 2^LANE_W and MUL is truncated.
- Reset asserted mid-RUN: immediate return to IDLE, result = 0, no done pulse.

Decomposition:
- Shared package holds:
  - Opcode constants: VOP_ADD = 3'b000, VOP_MUL = 3'b001.
  - FSM state encoding: IDLE, RUN, DONE.
  - Lane count and width defaults, shared with the ALU instance.
- No sub-module. The ALU is instantiated beside this block at the datapath level, not inside it, so both blocks stay independently testable.

Test Plan:
- ADD: LANES = 4; vec_a = 0x04030201, vec_b = 0x10203040, op = 000, start pulse -> done high 5 cycles after start, err = 0, result = 0x14233241.
- MUL with truncation: vec_a = 0x02100F03, vec_b = 0x03100211, op = 001 -> result = 0x06001E33 (lane 2 = 0x10 * 0x10 truncates to 0x00).
- ADD wrap: vec_a = 0xFFFFFFFF, vec_b = 0x01010101 -> result = 0x00000000. Lane 0 is driven first: valu_in1 = 0xFF and valu_in2 = 0x01 in cycle E0 to E1.
- Illegal op: op = 011, prior result = 0x14233241 -> done and err high in the cycle after start, busy high for 1 cycle, result unchanged.
- Reset mid-op: start ADD, assert reset after E2 -> busy = 0, result = 0, and no done pulse follows. The next start completes normally with the correct result.
- start held high continuously during an ADD -> busy = 0 for exactly one IDLE cycle after each done pulse, then a new operation starts. The second operation uses operands sampled at its own start edge.
